coms_frame_decoder: RTL and testbench

Motor-board-side receive stage for the motor control bus. It consumes the byte stream from uart_rx and hunts for the control-mode, setpoint and status-request frames issued by the bus master. It checks each frame's CRC-16 and filters frames by motor ID. Accepted frames update the setpoint and control-mode registers, or raise a status-request pulse for the status-frame transmitter.

---
 rtl/coms_pkg.sv | 42 ++++
 rtl/coms_frame_decoder.sv | 198 +++++++++++++++++++
 tb/tb_coms_frame_decoder.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coms_pkg.sv
// Shared definitions for the motor control bus framing: magic numbers,
// frame lengths, frame/FSM enums and the byte-wise CRC-16 update.
package coms_pkg;

    localparam logic [31:0] MAGIC_SETPOINT       = 32'hD0D0_D0D0;
    localparam logic [31:0] MAGIC_CONTROL_MODE   = 32'hBAAD_A555;
    localparam logic [31:0] MAGIC_STATUS_REQUEST = 32'h1CE1_CEBB;
    localparam logic [31:0] MAGIC_STATUS_REPLY   = 32'h1CEB_00DA;

    localparam int unsigned MAGIC_NUMBER_LENGTH          = 4;
    localparam int unsigned SETPOINT_FRAME_LENGTH        = 11;
    localparam int unsigned CONTROL_MODE_FRAME_LENGTH    = 8;
    localparam int unsigned STATUS_REQUEST_FRAME_LENGTH  = 7;
    localparam int unsigned STATUS_REPLY_FRAME_LENGTH    = 21;

    typedef enum logic [1:0] {
        FT_SETPOINT       = 2'd0,
        FT_CONTROL_MODE   = 2'd1,
        FT_STATUS_REQUEST = 2'd2
    } frame_type_t;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    // CRC-16 (poly 0x8005, MSB first, no reflection) advanced by one byte
    function automatic logic [15:0] nextCRC16_D8(input logic [7:0] data, input logic [15:0] crc);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h8005;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/coms_frame_decoder.sv
// Receive-side frame decoder for the motor control bus: hunts for magic
// numbers in the uart_rx byte stream, checks CRC-16, filters on motor ID and
// updates the setpoint / control-mode registers or pulses status_request.
// Optional inter-byte timeout is built when COMS_RX_TIMEOUT_EN is defined.
module coms_frame_decoder
    import coms_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned BAUDRATE       = 115200,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ_HZ / BAUDRATE * 40,
    parameter logic [7:0]  BROADCAST_ID   = 8'hFF
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               rx_data_ready,
    input  logic [7:0]         rx_data,
    input  logic [7:0]         motor_id,
    output logic signed [31:0] setpoint,
    output logic               setpoint_valid,
    output logic [7:0]         control_mode,
    output logic               control_mode_valid,
    output logic               status_request,
    output logic               crc_error,
    output logic               frame_timeout
);

    localparam int unsigned REM_W = 4;

    state_t             r_state;
    frame_type_t        r_type;
    logic [31:0]        r_shift;
    logic [REM_W-1:0]   r_remaining;
    logic [15:0]        r_crc_calc;
    logic [15:0]        r_crc_rx;
    logic [39:0]        r_pay;

    logic [31:0]        w_shift_next;
    logic               w_magic_hit;
    frame_type_t        w_magic_type;
    logic [REM_W-1:0]   w_magic_rem;
    logic [7:0]         w_id;
    logic               w_accept;

    assign w_shift_next = {r_shift[23:0], rx_data};

`ifdef COMS_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]    r_to_cnt;
`else
    logic               w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign frame_timeout    = 1'b0;
`endif

    // Recognise a known magic number completed by the incoming byte
    always_comb begin
        w_magic_hit  = 1'b0;
        w_magic_type = FT_SETPOINT;
        w_magic_rem  = '0;
        case (w_shift_next)
            MAGIC_SETPOINT: begin
                w_magic_hit  = 1'b1;
                w_magic_type = FT_SETPOINT;
                w_magic_rem  = REM_W'(SETPOINT_FRAME_LENGTH - MAGIC_NUMBER_LENGTH);
            end
            MAGIC_CONTROL_MODE: begin
                w_magic_hit  = 1'b1;
                w_magic_type = FT_CONTROL_MODE;
                w_magic_rem  = REM_W'(CONTROL_MODE_FRAME_LENGTH - MAGIC_NUMBER_LENGTH);
            end
            MAGIC_STATUS_REQUEST: begin
                w_magic_hit  = 1'b1;
                w_magic_type = FT_STATUS_REQUEST;
                w_magic_rem  = REM_W'(STATUS_REQUEST_FRAME_LENGTH - MAGIC_NUMBER_LENGTH);
            end
            default: ;
        endcase
    end

    // Extract the frame's ID byte and decide whether this board takes it
    always_comb begin
        w_id = r_pay[7:0];
        case (r_type)
            FT_SETPOINT:     w_id = r_pay[39:32];
            FT_CONTROL_MODE: w_id = r_pay[15:8];
            default:         w_id = r_pay[7:0];
        endcase
        w_accept = (w_id == motor_id) ||
                   ((w_id == BROADCAST_ID) && (r_type != FT_STATUS_REQUEST));
    end

    // Frame FSM with registered outputs
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state            <= HUNT;
            r_type             <= FT_SETPOINT;
            r_shift            <= '0;
            r_remaining        <= '0;
            r_crc_calc         <= 16'hFFFF;
            r_crc_rx           <= '0;
            r_pay              <= '0;
            setpoint           <= '0;
            setpoint_valid     <= 1'b0;
            control_mode       <= '0;
            control_mode_valid <= 1'b0;
            status_request     <= 1'b0;
            crc_error          <= 1'b0;
`ifdef COMS_RX_TIMEOUT_EN
            frame_timeout      <= 1'b0;
            r_to_cnt           <= '0;
`endif
        end else begin
            setpoint_valid     <= 1'b0;
            control_mode_valid <= 1'b0;
            status_request     <= 1'b0;
            crc_error          <= 1'b0;
`ifdef COMS_RX_TIMEOUT_EN
            frame_timeout      <= 1'b0;
`endif
            case (r_state)
                HUNT: begin
                    if (rx_data_ready) begin
                        if (w_magic_hit) begin
                            r_type      <= w_magic_type;
                            r_remaining <= w_magic_rem;
                            r_crc_calc  <= 16'hFFFF;
                            r_shift     <= '0;
                            r_pay       <= '0;
                            r_state     <= PAYLOAD;
`ifdef COMS_RX_TIMEOUT_EN
                            r_to_cnt    <= '0;
`endif
                        end else begin
                            r_shift <= w_shift_next;
                        end
                    end
                end

                PAYLOAD: begin
                    if (rx_data_ready) begin
                        // Payload bytes feed the CRC; the trailing two are the received CRC
                        if (r_remaining > REM_W'(2)) begin
                            r_pay      <= {r_pay[31:0], rx_data};
                            r_crc_calc <= nextCRC16_D8(rx_data, r_crc_calc);
                        end else begin
                            r_crc_rx   <= {r_crc_rx[7:0], rx_data};
                        end
                        r_remaining <= r_remaining - REM_W'(1);
                        if (r_remaining == REM_W'(1)) begin
                            r_state <= CHECK;
                        end
`ifdef COMS_RX_TIMEOUT_EN
                        r_to_cnt <= '0;
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Stalled sender: drop the partial frame silently
                        frame_timeout <= 1'b1;
                        r_shift       <= '0;
                        r_to_cnt      <= '0;
                        r_state       <= HUNT;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
                    end
                end

                CHECK: begin
                    // A byte landing here already belongs to the next hunt
                    if (rx_data_ready) begin
                        r_shift <= w_shift_next;
                    end
                    if (r_crc_calc == r_crc_rx) begin
                        if (w_accept) begin
                            case (r_type)
                                FT_SETPOINT: begin
                                    setpoint       <= r_pay[31:0];
                                    setpoint_valid <= 1'b1;
                                end
                                FT_CONTROL_MODE: begin
                                    control_mode       <= r_pay[7:0];
                                    control_mode_valid <= 1'b1;
                                end
                                default: begin
                                    status_request <= 1'b1;
                                end
                            endcase
                        end
                    end else begin
                        crc_error <= 1'b1;
                    end
                    r_state <= HUNT;
                end

                default: r_state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_coms_frame_decoder.sv
// Directed self-checking bench for coms_frame_decoder.
// Build with +define+COMS_RX_TIMEOUT_EN to exercise the timeout path.
module tb_coms_frame_decoder;

    localparam int unsigned TIMEOUT_CYCLES = 50_000_000 / 115200 * 40;

    logic               CLK = 1'b0;
    logic               reset = 1'b1;
    logic               rx_data_ready = 1'b0;
    logic [7:0]         rx_data = 8'h00;
    logic [7:0]         motor_id = 8'h00;
    logic signed [31:0] setpoint;
    logic               setpoint_valid;
    logic [7:0]         control_mode;
    logic               control_mode_valid;
    logic               status_request;
    logic               crc_error;
    logic               frame_timeout;

    int vecs = 0;
    int errs = 0;

    // Pulse counters, sampled on the falling edge
    int n_sp = 0, n_cm = 0, n_st = 0, n_ce = 0, n_to = 0;

    logic [7:0] frm[$];

    coms_frame_decoder dut (
        .CLK                (CLK),
        .reset              (reset),
        .rx_data_ready      (rx_data_ready),
        .rx_data            (rx_data),
        .motor_id           (motor_id),
        .setpoint           (setpoint),
        .setpoint_valid     (setpoint_valid),
        .control_mode       (control_mode),
        .control_mode_valid (control_mode_valid),
        .status_request     (status_request),
        .crc_error          (crc_error),
        .frame_timeout      (frame_timeout)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (setpoint_valid)     n_sp++;
        if (control_mode_valid) n_cm++;
        if (status_request)     n_st++;
        if (crc_error)          n_ce++;
        if (frame_timeout)      n_to++;
    end

    // Reference CRC step: XOR byte into the high half, then shift 8 times
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        repeat (8) r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        return r;
    endfunction

    task automatic build_frame(input logic [31:0] magic, input logic [7:0] id,
                               input logic [31:0] data, input int ndata, input bit flip);
        logic [15:0] c;
        frm.delete();
        for (int i = 3; i >= 0; i--) frm.push_back(magic[i*8 +: 8]);
        c = 16'hFFFF;
        frm.push_back(id);
        c = crc_step(c, id);
        for (int i = ndata - 1; i >= 0; i--) begin
            frm.push_back(data[i*8 +: 8]);
            c = crc_step(c, data[i*8 +: 8]);
        end
        frm.push_back(c[15:8]);
        frm.push_back(flip ? (c[7:0] ^ 8'h01) : c[7:0]);
    endtask

    // Sends frm[first..last]; caller is at a falling edge; no trailing gap
    task automatic send_range(input int first, input int last, input bit spaced);
        for (int i = first; i <= last; i++) begin
            rx_data_ready = 1'b1;
            rx_data       = frm[i];
            @(negedge CLK);
            if (spaced && i != last) begin
                rx_data_ready = 1'b0;
                @(negedge CLK);
            end
        end
        rx_data_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic test_reset;
        @(negedge CLK);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        vecs++;
        if (setpoint !== 32'sd0) begin errs++; $display("FAIL reset_setpoint got %h want 0", setpoint); end
        vecs++;
        if (control_mode !== 8'h00) begin errs++; $display("FAIL reset_mode got %h want 0", control_mode); end
        vecs++;
        if ({setpoint_valid, control_mode_valid, status_request, crc_error, frame_timeout} !== 5'b0) begin
            errs++;
            $display("FAIL reset_pulses got %b want 00000",
                     {setpoint_valid, control_mode_valid, status_request, crc_error, frame_timeout});
        end
    endtask

    task automatic test_status;
        int sp0 = n_sp, cm0 = n_cm, st0 = n_st, ce0 = n_ce;
        motor_id = 8'h00;
        frm = '{8'h1C, 8'hE1, 8'hCE, 8'hBB, 8'h00, 8'hFD, 8'h02};
        send_range(0, 6, 1'b1);
        vecs++;
        if (status_request !== 1'b0) begin errs++; $display("FAIL status_early got %b want 0", status_request); end
        @(negedge CLK);
        vecs++;
        if (status_request !== 1'b1) begin errs++; $display("FAIL status_pulse got %b want 1", status_request); end
        @(negedge CLK);
        vecs++;
        if (status_request !== 1'b0) begin errs++; $display("FAIL status_fall got %b want 0", status_request); end
        idle(3);
        vecs++;
        if (n_st - st0 != 1) begin errs++; $display("FAIL status_count got %0d want 1", n_st - st0); end
        vecs++;
        if ((n_sp - sp0) + (n_cm - cm0) + (n_ce - ce0) != 0 || setpoint !== 32'sd0 || control_mode !== 8'h00) begin
            errs++;
            $display("FAIL status_side_effects got sp=%0d cm=%0d ce=%0d want 0/0/0", n_sp - sp0, n_cm - cm0, n_ce - ce0);
        end
    endtask

    task automatic test_setpoint;
        int sp0 = n_sp, ce0 = n_ce;
        motor_id = 8'h03;
        build_frame(32'hD0D0D0D0, 8'h03, 32'hFFFFFF9C, 4, 1'b0);
        send_range(0, 10, 1'b1);
        idle(4);
        vecs++;
        if (setpoint !== -32'sd100) begin errs++; $display("FAIL setpoint_value got %0d want -100", setpoint); end
        vecs++;
        if (n_sp - sp0 != 1) begin errs++; $display("FAIL setpoint_pulse got %0d want 1", n_sp - sp0); end
        sp0 = n_sp;
        build_frame(32'hD0D0D0D0, 8'h03, 32'h00000005, 4, 1'b1);
        send_range(0, 10, 1'b1);
        idle(4);
        vecs++;
        if (n_ce - ce0 != 1) begin errs++; $display("FAIL crc_error_pulse got %0d want 1", n_ce - ce0); end
        vecs++;
        if (setpoint !== -32'sd100 || n_sp != sp0) begin
            errs++;
            $display("FAIL crc_error_hold got %0d (%0d pulses) want -100 (0 pulses)", setpoint, n_sp - sp0);
        end
    endtask

    task automatic test_control_broadcast;
        int cm0 = n_cm, st0 = n_st, ce0 = n_ce;
        motor_id = 8'h05;
        build_frame(32'hBAADA555, 8'hFF, 32'h00000002, 1, 1'b0);
        send_range(0, 7, 1'b1);
        idle(4);
        vecs++;
        if (control_mode !== 8'h02 || n_cm - cm0 != 1) begin
            errs++;
            $display("FAIL bcast_mode got %h (%0d pulses) want 02 (1 pulse)", control_mode, n_cm - cm0);
        end
        build_frame(32'h1CE1CEBB, 8'hFF, 32'h0, 0, 1'b0);
        send_range(0, 6, 1'b1);
        idle(4);
        vecs++;
        if (n_st != st0) begin errs++; $display("FAIL bcast_status got %0d pulses want 0", n_st - st0); end
        cm0 = n_cm;
        build_frame(32'hBAADA555, 8'h07, 32'h00000009, 1, 1'b0);
        send_range(0, 7, 1'b1);
        idle(4);
        vecs++;
        if (control_mode !== 8'h02 || n_cm != cm0 || n_ce != ce0) begin
            errs++;
            $display("FAIL foreign_id got mode %h cm %0d ce %0d want 02/0/0", control_mode, n_cm - cm0, n_ce - ce0);
        end
    endtask

    task automatic test_resync;
        int st0 = n_st, sp0 = n_sp, cm0 = n_cm, ce0 = n_ce;
        motor_id = 8'h00;
        frm = '{8'h1C, 8'h1C, 8'hE1, 8'hCE, 8'hBB, 8'h00, 8'hFD, 8'h02};
        send_range(0, 7, 1'b1);
        idle(4);
        vecs++;
        if (n_st - st0 != 1) begin errs++; $display("FAIL resync_status got %0d want 1", n_st - st0); end
        st0 = n_st;
        frm = '{8'h1C, 8'hEB, 8'h00, 8'hDA};
        repeat (17) frm.push_back(8'h00);
        send_range(0, 20, 1'b1);
        idle(4);
        vecs++;
        if (n_st != st0 || n_sp != sp0 || n_cm != cm0 || n_ce != ce0) begin
            errs++;
            $display("FAIL reply_ignored got st %0d sp %0d cm %0d ce %0d want all 0",
                     n_st - st0, n_sp - sp0, n_cm - cm0, n_ce - ce0);
        end
        build_frame(32'hD0D0D0D0, 8'h00, 32'hBAADA555, 4, 1'b0);
        send_range(0, 10, 1'b1);
        idle(4);
        vecs++;
        if (setpoint !== 32'hBAADA555 || n_sp - sp0 != 1 || n_cm != cm0 || control_mode !== 8'h02) begin
            errs++;
            $display("FAIL embedded_magic got sp %h (%0d) mode %h (%0d) want BAADA555 (1) 02 (0)",
                     setpoint, n_sp - sp0, control_mode, n_cm - cm0);
        end
    endtask

    task automatic test_reset_midframe;
        int sp0;
        motor_id = 8'h03;
        build_frame(32'hD0D0D0D0, 8'h03, 32'h12345678, 4, 1'b0);
        send_range(0, 5, 1'b1);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        sp0 = n_sp;
        send_range(6, 10, 1'b1);
        idle(4);
        vecs++;
        if (setpoint !== 32'sd0 || n_sp != sp0) begin
            errs++;
            $display("FAIL reset_midframe got %h (%0d pulses) want 0 (0 pulses)", setpoint, n_sp - sp0);
        end
        send_range(0, 10, 1'b1);
        idle(4);
        vecs++;
        if (setpoint !== 32'h12345678 || n_sp - sp0 != 1) begin
            errs++;
            $display("FAIL after_reset_frame got %h (%0d pulses) want 12345678 (1)", setpoint, n_sp - sp0);
        end
    endtask

    task automatic test_back_to_back;
        int cm0 = n_cm, st0 = n_st;
        motor_id = 8'h04;
        build_frame(32'hBAADA555, 8'h04, 32'h0000005A, 1, 1'b0);
        send_range(0, 7, 1'b0);
        rx_data_ready = 1'b1;
        build_frame(32'h1CE1CEBB, 8'h04, 32'h0, 0, 1'b0);
        send_range(0, 6, 1'b0);
        idle(4);
        vecs++;
        if (control_mode !== 8'h5A || n_cm - cm0 != 1) begin
            errs++;
            $display("FAIL b2b_mode got %h (%0d pulses) want 5A (1)", control_mode, n_cm - cm0);
        end
        vecs++;
        if (n_st - st0 != 1) begin errs++; $display("FAIL b2b_status got %0d want 1", n_st - st0); end
    endtask

    task automatic test_timeout;
        int sp0 = n_sp, ce0 = n_ce, to0 = n_to;
        motor_id = 8'h03;
        build_frame(32'hD0D0D0D0, 8'h03, 32'h00000777, 4, 1'b0);
        send_range(0, 5, 1'b1);
`ifdef COMS_RX_TIMEOUT_EN
        begin
            int waited = 0;
            while (n_to == to0 && waited < int'(TIMEOUT_CYCLES) + 50) begin
                @(negedge CLK);
                waited++;
            end
        end
        idle(2);
        vecs++;
        if (n_to - to0 != 1 || n_ce != ce0 || n_sp != sp0) begin
            errs++;
            $display("FAIL timeout_pulse got to %0d ce %0d sp %0d want 1/0/0", n_to - to0, n_ce - ce0, n_sp - sp0);
        end
        send_range(0, 10, 1'b1);
        idle(4);
        vecs++;
        if (setpoint !== 32'h00000777 || n_sp - sp0 != 1) begin
            errs++;
            $display("FAIL post_timeout_frame got %h (%0d pulses) want 00000777 (1)", setpoint, n_sp - sp0);
        end
`else
        idle(300);
        vecs++;
        if (n_to != to0) begin errs++; $display("FAIL timeout_disabled got %0d pulses want 0", n_to - to0); end
        send_range(6, 10, 1'b1);
        idle(4);
        vecs++;
        if (setpoint !== 32'h00000777 || n_sp - sp0 != 1 || n_ce != ce0) begin
            errs++;
            $display("FAIL stalled_frame got %h (%0d pulses, %0d crc) want 00000777 (1, 0)",
                     setpoint, n_sp - sp0, n_ce - ce0);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_status;
        test_setpoint;
        test_control_broadcast;
        test_resync;
        test_reset_midframe;
        test_back_to_back;
        test_timeout;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
